// File: rtl/fios_operand_feeder_if.sv
// fios_operand_feeder_if
//   Host-side load bus for the FIOS operand feeder. Each accepted word goes
//   into one operand register file, least-significant word first.
//
//   load_valid_i  host -> feeder  word valid
//   load_ready_o  feeder -> host  word accepted when high together with valid
//   load_sel_i    host -> feeder  target operand: 0=A, 1=B, 2=P, 3=never ready
//   load_data_i   host -> feeder  17-bit operand word
interface fios_operand_feeder_if;
  logic        load_valid_i;
  logic        load_ready_o;
  logic [1:0]  load_sel_i;
  logic [16:0] load_data_i;

  modport master (
    output load_valid_i,
    output load_sel_i,
    output load_data_i,
    input  load_ready_o
  );

  modport slave (
    input  load_valid_i,
    input  load_sel_i,
    input  load_data_i,
    output load_ready_o
  );
endinterface

// File: rtl/fios_operand_feeder.sv
// fios_operand_feeder
//   Operand staging buffer in front of the FIOS Montgomery multiplier. A, B
//   and P are loaded as streams of 17-bit words into local register files and
//   served to the multiplier during a run: a PE_NB-word window of A that moves
//   on a_shift_i, and single B/P words that advance cyclically on the fetch
//   strobes. Also produces the one-cycle multiplier start pulse and busy flag.
//
//   clock_i        rising-edge clock
//   reset_n_i      asynchronous active-low reset
//   load_if        host load bus (valid/ready/sel/data)
//   start_i        multiplication request, honoured in IDLE with all operands full
//   busy_o         high from accepted start until done
//   operands_ok_o  A, B and P each hold s words
//   fios_start_o   one-cycle start pulse (PRIME state)
//   a_shift_i      advance the A window by PE_NB words (RUN only)
//   b_fetch_i      advance the B word, wrapping after s-1 (RUN only)
//   p_fetch_i      advance the P word, wrapping after s-1 (RUN only)
//   done_i         multiplier completion strobe (RUN only)
//   a_o            A window, word k at bits [17k+16:17k], zero past the end
//   b_o            current B word
//   p_o            current P word
module fios_operand_feeder #(
  parameter int unsigned s     = 8,
  parameter int unsigned PE_NB = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  fios_operand_feeder_if.slave  load_if,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  operands_ok_o,
  output logic                  fios_start_o,
  input  logic                  a_shift_i,
  input  logic                  b_fetch_i,
  input  logic                  p_fetch_i,
  input  logic                  done_i,
  output logic [PE_NB*17-1:0]   a_o,
  output logic [16:0]           b_o,
  output logic [16:0]           p_o
);

  // Word index into a register file.
  localparam int unsigned IW   = (s > 1) ? $clog2(s) : 1;
  // Write counter spans 0..s.
  localparam int unsigned WCW  = $clog2(s + 1);
  // A window base saturates at the first multiple of PE_NB that is >= s.
  localparam int unsigned ASAT = ((s + PE_NB - 1) / PE_NB) * PE_NB;
  localparam int unsigned AW   = $clog2(ASAT + 1);

  localparam logic [WCW-1:0] WC_FULL   = WCW'(s);
  localparam logic [WCW-1:0] WC_LAST   = WCW'(s - 1);
  localparam logic [IW-1:0]  PTR_LAST  = IW'(s - 1);
  localparam logic [AW-1:0]  A_LIMIT   = AW'(s);
  localparam logic [AW-1:0]  A_STEP    = AW'(PE_NB);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int unsigned OP_A = 0;
  localparam int unsigned OP_B = 1;
  localparam int unsigned OP_P = 2;

  logic [1:0]     state;

  // Operand register files, write counters and full flags, indexed by
  // operand (0=A, 1=B, 2=P) to match load_sel_i directly.
  logic [16:0]    mem  [3][s];
  logic [WCW-1:0] wc   [3];
  logic [2:0]     full;

  logic [AW-1:0]  a_base;
  logic [IW-1:0]  b_ptr;
  logic [IW-1:0]  p_ptr;

  logic           load_ready;
  logic           load_fire;
  logic           start_ok;

  // ---------------------------------------------------------------------------
  // Load handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready = 1'b0;
    if (state == ST_IDLE) begin
      unique case (load_if.load_sel_i)
        2'd0:    load_ready = (wc[OP_A] < WC_FULL);
        2'd1:    load_ready = (wc[OP_B] < WC_FULL);
        2'd2:    load_ready = (wc[OP_P] < WC_FULL);
        default: load_ready = 1'b0;
      endcase
    end
  end

  assign load_if.load_ready_o = load_ready;
  assign load_fire            = load_if.load_valid_i && load_ready;

  assign operands_ok_o = &full;
  assign start_ok      = (state == ST_IDLE) && start_i && operands_ok_o;

  // ---------------------------------------------------------------------------
  // Register files, write counters, full flags
  // ---------------------------------------------------------------------------
  // A load and an accepted start can coincide in IDLE: the word and its flag
  // update still land, but the counter clear from the start takes precedence.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned op = 0; op < 3; op++) begin
        for (int unsigned i = 0; i < s; i++) begin
          mem[op][i] <= '0;
        end
        wc[op] <= '0;
      end
      full <= '0;
    end else begin
      if (load_fire) begin
        mem[load_if.load_sel_i][wc[load_if.load_sel_i][IW-1:0]] <= load_if.load_data_i;
        wc[load_if.load_sel_i] <= wc[load_if.load_sel_i] + 1'b1;
        // Starting a reload invalidates the operand until the last word lands.
        if (wc[load_if.load_sel_i] == '0) begin
          full[load_if.load_sel_i] <= 1'b0;
        end
        if (wc[load_if.load_sel_i] == WC_LAST) begin
          full[load_if.load_sel_i] <= 1'b1;
        end
      end
      if (start_ok) begin
        for (int unsigned op = 0; op < 3; op++) begin
          wc[op] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and read pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      a_base <= '0;
      b_ptr  <= '0;
      p_ptr  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state  <= ST_PRIME;
            a_base <= '0;
            b_ptr  <= '0;
            p_ptr  <= '0;
          end
        end

        ST_PRIME: begin
          state <= ST_RUN;
        end

        ST_RUN: begin
          // done_i wins over any strobe in the same cycle.
          if (done_i) begin
            state  <= ST_IDLE;
            a_base <= '0;
            b_ptr  <= '0;
            p_ptr  <= '0;
          end else begin
            if (a_shift_i && (a_base < A_LIMIT)) begin
              a_base <= a_base + A_STEP;
            end
            if (b_fetch_i) begin
              b_ptr <= (b_ptr == PTR_LAST) ? '0 : b_ptr + 1'b1;
            end
            if (p_fetch_i) begin
              p_ptr <= (p_ptr == PTR_LAST) ? '0 : p_ptr + 1'b1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          a_base <= '0;
          b_ptr  <= '0;
          p_ptr  <= '0;
        end
      endcase
    end
  end

  assign busy_o       = (state != ST_IDLE);
  assign fios_start_o = (state == ST_PRIME);

  // ---------------------------------------------------------------------------
  // Operand outputs
  // ---------------------------------------------------------------------------
  // Window words beyond the last A word read as zero (FOLD padding).
  always_comb begin
    int unsigned idx;
    idx = 0;
    a_o = '0;
    for (int unsigned k = 0; k < PE_NB; k++) begin
      idx = 32'(a_base) + k;
      if (idx < s) begin
        a_o[17*k +: 17] = mem[OP_A][IW'(idx)];
      end
    end
  end

  assign b_o = mem[OP_B][b_ptr];
  assign p_o = mem[OP_P][p_ptr];

endmodule

// File: tb/tb_fios_operand_feeder.sv
module tb_fios_operand_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [16:0] data = '0;
  logic        start = 1'b0;
  logic        ashift = 1'b0;
  logic        bfetch = 1'b0;
  logic        pfetch = 1'b0;
  logic        done = 1'b0;

  logic          busy8, ok8, fs8;
  logic [135:0]  a8;
  logic [16:0]   b8, p8;
  logic          busy3, ok3, fs3;
  logic [50:0]   a3;
  logic [16:0]   b3, p3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fios_operand_feeder_if lif8 ();
  fios_operand_feeder_if lif3 ();

  assign lif8.load_valid_i = valid;
  assign lif8.load_sel_i   = sel;
  assign lif8.load_data_i  = data;
  assign lif3.load_valid_i = valid;
  assign lif3.load_sel_i   = sel;
  assign lif3.load_data_i  = data;

  // EXPAND instance: window covers all of A.
  fios_operand_feeder #(.s(8), .PE_NB(8)) u_dut8 (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .load_if       (lif8.slave),
    .start_i       (start),
    .busy_o        (busy8),
    .operands_ok_o (ok8),
    .fios_start_o  (fs8),
    .a_shift_i     (ashift),
    .b_fetch_i     (bfetch),
    .p_fetch_i     (pfetch),
    .done_i        (done),
    .a_o           (a8),
    .b_o           (b8),
    .p_o           (p8)
  );

  // FOLD instance: 3-word window over the same stimulus.
  fios_operand_feeder #(.s(8), .PE_NB(3)) u_dut3 (
    .clock_i       (clk),
    .reset_n_i     (rst_n),
    .load_if       (lif3.slave),
    .start_i       (start),
    .busy_o        (busy3),
    .operands_ok_o (ok3),
    .fios_start_o  (fs3),
    .a_shift_i     (ashift),
    .b_fetch_i     (bfetch),
    .p_fetch_i     (pfetch),
    .done_i        (done),
    .a_o           (a3),
    .b_o           (b3),
    .p_o           (p3)
  );

  localparam logic [135:0] A8_INIT =
    {17'd8, 17'd7, 17'd6, 17'd5, 17'd4, 17'd3, 17'd2, 17'd1};
  localparam logic [135:0] A8_ONE =
    {17'd8, 17'd7, 17'd6, 17'd5, 17'd4, 17'd3, 17'd2, 17'h0005A};
  localparam logic [50:0] A3_W0 = {17'd3, 17'd2, 17'd1};
  localparam logic [50:0] A3_W1 = {17'd6, 17'd5, 17'd4};
  localparam logic [50:0] A3_W2 = {17'd0, 17'd8, 17'd7};

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [1:0] s_sel, input logic [16:0] s_data);
    valid = 1'b1;
    sel   = s_sel;
    data  = s_data;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_ok", ok8, 0);
    chk("rst_fstart", fs8, 0);
    chk("rst_a8", a8, 0);
    chk("rst_b8", b8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_a3", a3, 0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk("rst_ready", lif8.load_ready_o, (i != 3) ? 1 : 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load A = 1..8
    for (int i = 0; i < 8; i++) ld(2'd0, 17'(i + 1));
    sel = 2'd0;
    #1;
    chk("a_full_ready", lif8.load_ready_o, 0);
    sel = 2'd1;
    #1;
    chk("b_empty_ready", lif8.load_ready_o, 1);

    // Load B = 0x10..0x17, P = 7 x 0x1FFFF
    for (int i = 0; i < 8; i++) ld(2'd1, 17'(16 + i));
    for (int i = 0; i < 7; i++) ld(2'd2, 17'h1FFFF);
    chk("ok_p7", ok8, 0);
    sel = 2'd2;
    #1;
    chk("p7_ready", lif8.load_ready_o, 1);

    // Start with P incomplete is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("early_start_busy", busy8, 0);
    chk("early_start_fs", fs8, 0);

    // 24th handshake
    ld(2'd2, 17'h1FFFF);
    chk("ok_after_24", ok8, 1);
    chk("ok3_after_24", ok3, 1);
    sel = 2'd2;
    #1;
    chk("p_full_ready", lif8.load_ready_o, 0);
    sel = 2'd3;
    #1;
    chk("sel3_ready", lif8.load_ready_o, 0);

    // Accepted start: PRIME cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("prime_busy", busy8, 1);
    chk("prime_fs", fs8, 1);
    chk("prime_a8", a8, A8_INIT);
    chk("prime_a3", a3, A3_W0);
    chk("prime_b8", b8, 17'h10);
    chk("prime_p8", p8, 17'h1FFFF);
    sel = 2'd0;
    #1;
    chk("busy_ready", lif8.load_ready_o, 0);
    tick();
    chk("run_fs", fs8, 0);
    chk("run_busy", busy8, 1);

    // B wrap: 9 fetches
    bfetch = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("b_wrap", b8, 17'(16 + ((i + 1) % 8)));
    end
    bfetch = 1'b0;
    chk("p_hold", p8, 17'h1FFFF);

    // FOLD window shifts
    ashift = 1'b1;
    tick();
    chk("fold_w1", a3, A3_W1);
    chk("expand_shift", a8, 0);
    tick();
    chk("fold_w2", a3, A3_W2);
    tick();
    chk("fold_w3", a3, 0);
    tick();
    chk("fold_sat4", a3, 0);
    repeat (10) tick();
    chk("fold_sat_many", a3, 0);
    ashift = 1'b0;

    // done together with a fetch
    done   = 1'b1;
    bfetch = 1'b1;
    tick();
    done   = 1'b0;
    bfetch = 1'b0;
    chk("done_busy", busy8, 0);
    chk("done_b8", b8, 17'h10);
    chk("done_ok", ok8, 1);
    chk("done_a3", a3, A3_W0);
    sel = 2'd0;
    #1;
    chk("done_ready", lif8.load_ready_o, 1);

    // Restart without reload
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy8, 1);
    chk("restart_fs", fs8, 1);
    chk("restart_a8", a8, A8_INIT);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("restart_done", busy8, 0);

    // Partial reload of A blocks start
    ld(2'd0, 17'h0005A);
    chk("partial_ok", ok8, 0);
    chk("partial_a8", a8, A8_ONE);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("partial_start_busy", busy8, 0);
    chk("partial_start_fs", fs8, 0);

    // Finish reload, run, then reset mid-RUN
    for (int i = 1; i < 8; i++) ld(2'd0, 17'(i + 1));
    chk("reload_ok", ok8, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bfetch = 1'b1;
    tick();
    tick();
    bfetch = 1'b0;
    chk("pre_reset_b8", b8, 17'h12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_ok", ok8, 0);
    chk("mid_rst_fs", fs8, 0);
    chk("mid_rst_a8", a8, 0);
    chk("mid_rst_b8", b8, 0);
    chk("mid_rst_p8", p8, 0);
    chk("mid_rst_a3", a3, 0);
    sel = 2'd0;
    #1;
    chk("mid_rst_ready", lif8.load_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ok", ok8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fios_operand_feeder.md
# fios_operand_feeder

Operand staging buffer that sits directly upstream of the FIOS Montgomery multiplier top level. It accepts the A, B and P operands as streams of 17-bit words from the host side and holds them in local register files. During a multiplication it serves them to the multiplier: a PE_NB-word window of A that advances on each A-shift strobe, and B and P words that advance cyclically on the fetch strobes. It also generates the single-cycle start pulse and tracks busy/idle around the multiplier's done strobe.

## Interface
Parameters:
- s, 8: number of 17-bit words per operand; minimum 2.
- PE_NB, 8: number of words in the A window. Must equal the multiplier's PE count: s for EXPAND, fewer for FOLD.

Ports:
- clock_i  in  1  single clock, all logic rising-edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- load_valid_i  in  1  load word valid.
- load_ready_o  out  1  load word accepted when high together with valid.
- load_sel_i  in  2  target operand: 0=A, 1=B, 2=P; 3 is never ready.
- load_data_i  in  17  operand word, least-significant word first.
- start_i  in  1  multiplication request.
- busy_o  out  1  high from accepted start until done.
- operands_ok_o  out  1  all three operands hold s words.
- fios_start_o  out  1  one-cycle start pulse to the multiplier.
- a_shift_i  in  1  advance the A window by PE_NB words.
- b_fetch_i  in  1  advance the B word.
- p_fetch_i  in  1  advance the P word.
- done_i  in  1  multiplier completion strobe.
- a_o  out  PE_NB*17  A window; word k is at bits [17k+16:17k].
- b_o  out  17  current B word.
- p_o  out  17  current P word.

## Operation
- Storage: three s×17 register files (A, B, P). Each operand has:
  - a write counter wc_X in 0..s;
  - a full flag f_X.
- FSM states: IDLE, PRIME, RUN.
- Loading (IDLE only):
  - load_ready_o = (state==IDLE) && sel≠3 && wc_sel<s.
  - On handshake, X[wc_X] <= data and wc_X++.
  - A write with wc_X==0 clears f_X. f_X is set when wc_X reaches s.
- operands_ok_o = f_A & f_B & f_P.
- IDLE → PRIME: on start_i && operands_ok_o. Otherwise start_i is ignored.
  - On the transition: all wc_X <= 0, f_X unchanged, a_base <= 0, b_ptr <= 0, p_ptr <= 0, busy_o <= 1.
  - Operands are therefore reusable: a repeated start without reloading is legal.
  - Reloading any operand requires writing all s words; until then f_X stays clear.
- PRIME → RUN: unconditional after one cycle; fios_start_o = 1 in the PRIME cycle only.
- RUN:
  - a_shift_i: a_base += PE_NB.
  - b_fetch_i: b_ptr = (b_ptr==s-1) ? 0 : b_ptr+1.
  - p_fetch_i: same rule on p_ptr.
  - Simultaneous strobes are each applied independently.
- RUN → IDLE: on done_i. busy_o <= 0 and pointers reset to 0. done_i has priority over strobes in the same cycle.
- Outputs:
  - a_o word k = A[a_base+k] if a_base+k < s, else 0. This is the FOLD zero padding.
  - b_o = B[b_ptr], p_o = P[p_ptr]. Both are valid continuously, from registered pointers.
- Strobes and done_i outside RUN are ignored. start_i outside IDLE is ignored.
- a_base saturates at the first multiple of PE_NB that is ≥ s. Further shifts are ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert edge assumed):
  - state IDLE; all counters, flags, pointers and register files 0.
  - load_ready_o = 1 for sel 0..2.
  - busy_o = 0, operands_ok_o = 0, fios_start_o = 0, a_o/b_o/p_o = 0.
- Load: a word written in cycle n is visible on outputs from cycle n+1.
- Start: start_i sampled in cycle n → busy_o = 1 and fios_start_o = 1 in cycle n+1 (PRIME) → RUN from n+2.
  - a_o, b_o and p_o show index 0 from cycle n+1, i.e. no later than the start pulse.
- Strobe in cycle n → the new word appears on b_o/p_o/a_o in cycle n+1.
- done_i in cycle n → busy_o = 0 and load_ready_o = 1 in cycle n+1. start_i is accepted again from cycle n+1.
- Reset asserted mid-RUN → immediate return to the reset state, including cleared f_X; the operands must be reloaded.

## Test plan
- **Reset and load:** reset, then load A=1..8, B=0x10..0x17, P=0x1FFFF×8 (s=8).
  - operands_ok_o rises the cycle after the 24th handshake.
  - load_ready_o drops for a sel once 8 words are written to it; sel=3 is never ready.
- **Start handshake:** start_i with B loaded but only 7 words in P → ignored, busy_o stays 0.
  - After the 8th P word, start_i → fios_start_o pulses exactly one cycle, one cycle later; a_o = {8,7,…,1}.
- **B/P wrap:** in RUN, 9 b_fetch_i pulses → b_o sequence 0x11..0x17, 0x10, 0x11. p_o is unchanged without p_fetch_i.
- **FOLD window:** s=8, PE_NB=3; shifts move a_o from {3,2,1} to {6,5,4} to {0,8,7}. A 4th shift is ignored.
- **Done and reuse:** done_i together with b_fetch_i → busy_o = 0, b_o = B[0].
  - A restart without reload is accepted.
  - Writing one A word then start_i → ignored, because f_A is clear.
- **Reset mid-run:** reset_n_i pulsed low mid-RUN → all outputs 0 asynchronously, operands_ok_o = 0.
